data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe.sv | 133 +++++++++++++
 tb/tb_data_mem_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-enabled data memory with in-order, back-pressured responses.
// Define DMEM_ERR_EN to flag out-of-range / misaligned accesses on err_o.
module data_mem_pipe #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1 << (ADDR_WIDTH - 2),
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int OFF  = $clog2(BE_W);
  localparam int IW   = ADDR_WIDTH - OFF;
  localparam int MW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW   = $clog2(RESP_DEPTH + 1);
  localparam int AGW  = 3;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] rd_q  [RESP_DEPTH];
  logic [AGW-1:0]        age_q [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;

  logic [IW-1:0]         idx;
  logic                  in_range;
  logic                  ok;
  logic                  acc;
  logic                  pop;
  logic [BE_W-1:0]       be_eff;
  logic [DATA_WIDTH-1:0] rdat;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == RESP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign idx      = addr_i[ADDR_WIDTH-1:OFF];
  assign in_range = int'(idx) < MEM_DEPTH;

`ifdef DMEM_ERR_EN
  logic mis;
  logic err_q [RESP_DEPTH];

  assign mis = (addr_i & ADDR_WIDTH'(BE_W - 1)) != '0;
  assign ok  = in_range & ~mis;
`else
  logic unused_lsb;

  assign unused_lsb = ^addr_i;
  assign ok         = in_range;
`endif

  // cnt counts accepted-but-unpopped responses, so it bounds the FIFO
  assign gnt_o    = req_i & rst_n & (int'(cnt) < RESP_DEPTH);
  assign acc      = gnt_o;
  assign rvalid_o = (cnt != '0) && (int'(age_q[rd_ptr]) >= LATENCY);
  assign pop      = rvalid_o & rready_i;
  assign rdata_o  = rvalid_o ? rd_q[rd_ptr] : '0;

  assign be_eff = (be_i == '0) ? '1 : be_i;
  assign rdat   = (ok & ~we_i) ? mem[idx[MW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (acc && we_i && ok) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_eff[b]) begin
          mem[idx[MW-1:0]][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // age saturates at LATENCY; head is presentable once it gets there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        rd_q[i]  <= '0;
        age_q[i] <= '0;
      end
    end else begin
      if (acc) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      if (acc && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (!acc && pop) begin
        cnt <= cnt - 1'b1;
      end
      for (int i = 0; i < RESP_DEPTH; i++) begin
        if (acc && PW'(i) == wr_ptr) begin
          rd_q[i]  <= rdat;
          age_q[i] <= AGW'(1);
        end else if (int'(age_q[i]) < LATENCY) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef DMEM_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) err_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        if (acc && PW'(i) == wr_ptr) err_q[i] <= ~ok;
      end
    end
  end

  assign err_o = rvalid_o & err_q[rd_ptr];
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: byte writes, latency, back-pressure,
// range/alignment errors, reset with traffic in flight.
module tb_data_mem_pipe;

`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } resp_t;

  resp_t q[$];

  data_mem_pipe #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .MEM_DEPTH (512),
    .LATENCY   (2),
    .RESP_DEPTH(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .gnt_o   (gnt),
    .we_i    (we),
    .be_i    (be),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rvalid_o(rvalid),
    .rready_i(rready),
    .rdata_o (rdata),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // inputs change at posedge+1, so negedge values predict the next edge
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) q.push_back('{rdata, err, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [3:0] b,
                       input logic [11:0] a, input logic [31:0] d,
                       input bit gnt_now);
    int k;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
    if (gnt_now) check("gnt_now", {31'b0, gnt}, 32'd1);
    k = 0;
    while (!gnt && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!gnt) check("gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic get(output logic [31:0] d, output logic e,
                     output int n, output int c);
    resp_t r;
    n = 0;
    while (q.size() == 0 && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    if (q.size() == 0) begin
      check("resp_timeout", 32'd0, 32'd1);
      d = '0; e = 1'b0; c = 0;
    end else begin
      r = q.pop_front();
      d = r.d; e = r.e; c = r.c;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] d;
  logic        e;
  int          n;
  int          c;
  int          c0;

  initial begin
    rst_n = 1'b0; req = 1'b1; we = 1'b0; be = '0;
    addr = '0; wdata = '0; rready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", {31'b0, gnt}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;

    issue(1'b1, 4'hF, 12'h010, 32'hDEADBEEF, 1'b1);
    get(d, e, n, c);
    check("wr_rdata", d, 32'd0);
    check("wr_lat", n, 32'd2);
    issue(1'b0, 4'hF, 12'h010, 32'd0, 1'b0);
    get(d, e, n, c);
    check("rd_full", d, 32'hDEADBEEF);
    check("rd_lat", n, 32'd2);

    issue(1'b1, 4'h4, 12'h010, 32'h00AA0000, 1'b0);
    get(d, e, n, c);
    issue(1'b0, 4'hF, 12'h010, 32'd0, 1'b0);
    get(d, e, n, c);
    check("rd_byte2", d, 32'hDEAABEEF);
    issue(1'b1, 4'h0, 12'h014, 32'h12345678, 1'b0);
    get(d, e, n, c);
    issue(1'b0, 4'hF, 12'h014, 32'd0, 1'b0);
    get(d, e, n, c);
    check("rd_be0", d, 32'h12345678);

    rready = 1'b0;
    req = 1'b1; we = 1'b0; addr = 12'h010;
    @(negedge clk);
    check("bp_gnt1", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1; addr = 12'h014;
    @(negedge clk);
    check("bp_gnt2", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1; addr = 12'h010;
    @(negedge clk);
    check("bp_gnt3_blk", {31'b0, gnt}, 32'd0);
    check("bp_rvalid", {31'b0, rvalid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_gnt3_hold", {31'b0, gnt}, 32'd0);
    check("bp_rdata_hold", rdata, 32'hDEAABEEF);
    @(posedge clk); #1; rready = 1'b1;
    @(negedge clk);
    check("bp_gnt_prepop", {31'b0, gnt}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_gnt_postpop", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1; req = 1'b0;
    get(d, e, n, c);
    check("bp_ord0", d, 32'hDEAABEEF);
    get(d, e, n, c);
    check("bp_ord1", d, 32'h12345678);
    get(d, e, n, c);
    check("bp_ord2", d, 32'hDEAABEEF);

    issue(1'b0, 4'hF, 12'hFFC, 32'd0, 1'b0);
    get(d, e, n, c);
    check("oor_rdata", d, 32'd0);
    check("oor_err", {31'b0, e}, {31'b0, ERR});
    issue(1'b1, 4'hF, 12'hFFC, 32'h55555555, 1'b0);
    get(d, e, n, c);
    check("oor_wr_err", {31'b0, e}, {31'b0, ERR});
    issue(1'b0, 4'hF, 12'h011, 32'd0, 1'b0);
    get(d, e, n, c);
    check("mis_rdata", d, ERR ? 32'd0 : 32'hDEAABEEF);
    check("mis_err", {31'b0, e}, {31'b0, ERR});

    rready = 1'b0;
    req = 1'b1; we = 1'b0; addr = 12'h010;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    check("rst2_pre_rvalid", {31'b0, rvalid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b1;
    #1;
    check("rst2_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst2_gnt", {31'b0, gnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0; rready = 1'b1;
    issue(1'b0, 4'hF, 12'h010, 32'd0, 1'b1);
    get(d, e, n, c);
    check("rst2_mem_kept", d, 32'hDEAABEEF);
    check("rst2_flushed", q.size(), 32'd0);

    req = 1'b1; we = 1'b1; be = 4'hF;
    addr = 12'h020; wdata = 32'h0BADF00D;
    @(negedge clk);
    check("b2b_gnt_wr", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1; we = 1'b0;
    @(negedge clk);
    check("b2b_gnt_rd", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1; req = 1'b0;
    get(d, e, n, c0);
    check("b2b_wr_rdata", d, 32'd0);
    get(d, e, n, c);
    check("b2b_rd_rdata", d, 32'h0BADF00D);
    check("b2b_no_gap", c - c0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
